// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug command path: command width, command bit
// positions and the transmitter state encoding.
package dbg_cmd_pkg;

  localparam int CMD_W = 29;
  localparam int FRAME_BYTES = 4;

  // Bit positions inside a 29-bit command word.
  localparam int CMD_CONT_EN  = 0;
  localparam int CMD_PAUSE_R  = 1;
  localparam int CMD_PAUSE_W  = 2;
  localparam int CMD_DROP_R   = 3;
  localparam int CMD_DROP_W   = 4;
  localparam int CMD_INJ_R    = 5;
  localparam int CMD_INJ_W    = 6;
  localparam int CMD_LOG_EN   = 7;
  localparam int CMD_LOG_R    = 8;
  localparam int CMD_LOG_W    = 9;
  localparam int CMD_LOG_ERR  = 10;
  localparam int CMD_LOG_CLR  = 11;
  localparam int CMD_INJ_RESP = 12;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } tx_state_t;

endpackage

// File: rtl/dbg_cmd_slot.sv
// Single-entry valid/ready output register. A load and a drain in the same
// cycle keep the slot full with the new word, so back-to-back beats have no bubble.
module dbg_cmd_slot #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready,
  output logic         fire
);

  assign fire = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dbg_cmd_tx.sv
// Host byte stream to 29-bit debug command transmitter with frame validation
// and sent/error counters. Optional inter-byte timeout: DBG_CMD_TX_TIMEOUT_EN.
module dbg_cmd_tx #(
  parameter int CMD_W          = 29,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_TDATA,
  input  logic             in_TVALID,
  output logic             in_TREADY,
  input  logic             in_TLAST,
  output logic [CMD_W-1:0] cmd_out_TDATA,
  output logic             cmd_out_TVALID,
  input  logic             cmd_out_TREADY,
  output logic [CNT_W-1:0] cmd_sent_count,
  output logic [7:0]       err_count,
  output logic             err_pulse
);

  import dbg_cmd_pkg::*;

  // Both streams use AXI-Stream semantics: a beat transfers on the rising edge
  // where VALID && READY; VALID never depends on READY and, once raised, holds
  // with stable data until the transfer.

  tx_state_t   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic        in_beat;
  logic        slot_valid;
  logic        slot_fire;
  logic        load;
  logic        err_ev;
  logic        timeout_hit;
  logic [31:0] raw;

  // The 4th byte is held off only while the slot is full and not draining.
  assign in_TREADY = !rst && !(state_q == COLLECT && idx_q == 2'd3 &&
                               slot_valid && !cmd_out_TREADY);
  assign in_beat   = in_TVALID && in_TREADY;
  assign raw       = {in_TDATA, shift_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_beat) begin
          if (idx_q != 2'd3) begin
            if (in_TLAST) begin
              err_ev = 1'b1;
              idx_d  = 2'd0;
            end else begin
              case (idx_q)
                2'd0:    shift_d[7:0]   = in_TDATA;
                2'd1:    shift_d[15:8]  = in_TDATA;
                default: shift_d[23:16] = in_TDATA;
              endcase
              idx_d = idx_q + 2'd1;
            end
          end else if (in_TLAST) begin
            idx_d = 2'd0;
            // Reserved bits must be clear and null commands are never issued.
            if (raw[31:CMD_W] != '0 || raw[CMD_W-1:0] == '0) err_ev = 1'b1;
            else load = 1'b1;
          end else begin
            err_ev  = 1'b1;
            idx_d   = 2'd0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_beat && in_TLAST) state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        idx_d   = 2'd0;
      end
    endcase
    if (timeout_hit) begin
      // A frame already in DRAIN was counted on entry.
      if (state_q == COLLECT) err_ev = 1'b1;
      state_d = COLLECT;
      idx_d   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= COLLECT;
      idx_q          <= 2'd0;
      shift_q        <= '0;
      cmd_sent_count <= '0;
      err_count      <= '0;
      err_pulse      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      err_pulse <= err_ev;
      if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (slot_fire) cmd_sent_count <= cmd_sent_count + 1'b1;
    end
  end

`ifdef DBG_CMD_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_active;

  assign to_active   = (state_q == COLLECT && idx_q != 2'd0) || state_q == DRAIN;
  assign timeout_hit = to_active && !in_beat && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !to_active || in_beat || timeout_hit) to_cnt <= '0;
    else to_cnt <= to_cnt + 1'b1;
  end
`else
  // Without the timeout a partial frame waits indefinitely.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
`endif

  dbg_cmd_slot #(.W(CMD_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (raw[CMD_W-1:0]),
    .valid     (slot_valid),
    .data      (cmd_out_TDATA),
    .ready     (cmd_out_TREADY),
    .fire      (slot_fire)
  );

  assign cmd_out_TVALID = slot_valid;

endmodule

// File: tb/tb_dbg_cmd_tx.sv
// Self-checking bench for dbg_cmd_tx: directed steps plus randomized frames
// checked against a frame-level reference model.
module tb_dbg_cmd_tx;

  localparam int CMD_W = 29;
  localparam int CNT_W = 16;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_TDATA;
  logic             in_TVALID;
  logic             in_TREADY;
  logic             in_TLAST;
  logic [CMD_W-1:0] cmd_out_TDATA;
  logic             cmd_out_TVALID;
  logic             cmd_out_TREADY;
  logic [CNT_W-1:0] cmd_sent_count;
  logic [7:0]       err_count;
  logic             err_pulse;

  always #5 clk = ~clk;

  dbg_cmd_tx #(.CMD_W(CMD_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_TDATA       (in_TDATA),
    .in_TVALID      (in_TVALID),
    .in_TREADY      (in_TREADY),
    .in_TLAST       (in_TLAST),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .cmd_out_TREADY (cmd_out_TREADY),
    .cmd_sent_count (cmd_sent_count),
    .err_count      (err_count),
    .err_pulse      (err_pulse)
  );

  int n_checks = 0;
  int n_err    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int exp_err  = 0;
  int exp_sent = 0;
  int err_seen = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic [CMD_W-1:0] got_q[$];

  // Observe output handshakes and error pulses between clock edges.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (cmd_out_TVALID && cmd_out_TREADY) got_q.push_back(cmd_out_TDATA);
      if (err_pulse) err_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       cmd_out_TREADY = 1'b1;
      1:       cmd_out_TREADY = 1'($urandom_range(0, 1));
      default: cmd_out_TREADY = 1'b0;
    endcase
  endtask

  // Frame-level model: only 4-byte frames with clear reserved bits and a
  // nonzero command are issued; everything else costs one error.
  function automatic void model_frame(input byte_q_t fb);
    logic [31:0] v;
    if (fb.size() != 4) begin
      exp_err++;
      return;
    end
    v = {fb[3], fb[2], fb[1], fb[0]};
    if (v[31:29] != 3'd0 || v[28:0] == 29'd0) exp_err++;
    else begin
      exp_q.push_back(v[28:0]);
      exp_sent++;
    end
  endfunction

  function automatic byte_q_t word_bytes(input logic [31:0] v);
    byte_q_t q;
    for (int i = 0; i < 4; i++) q.push_back(v[8*i +: 8]);
    return q;
  endfunction

  function automatic logic [31:0] rand_word();
    int r;
    logic [31:0] v;
    r = $urandom_range(0, 9);
    if (r == 0) v = {3'($urandom_range(1, 7)), 29'($urandom)};
    else if (r == 1) v = 32'd0;
    else begin
      v = {3'b000, 29'($urandom)};
      if (v == 32'd0) v = 32'd1;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_cmd();
    logic [31:0] v;
    v = {3'b000, 29'($urandom)};
    if (v == 32'd0) v = 32'd7;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    in_TDATA  = b;
    in_TLAST  = last;
    in_TVALID = 1'b1;
    while (!done) begin
      #1;
      done = in_TREADY;
      tick();
      n++;
      if (!done && n > 500) begin
        chk("in_handshake_bound", {31'd0, in_TREADY}, 32'd1);
        done = 1'b1;
      end
    end
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t fb);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], i == fb.size() - 1);
    model_frame(fb);
  endtask

  // Let the slot drain, then compare everything delivered against the model.
  task automatic settle(input string tag);
    rdy_mode = 0;
    repeat (6) tick();
    chk({tag, "_ncmd"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_cmd"}, {3'b000, got_q.pop_front()}, {3'b000, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
    chk({tag, "_sent"}, {16'd0, cmd_sent_count}, exp_sent % 65536);
    chk({tag, "_errcnt"}, {24'd0, err_count}, (exp_err > 255) ? 255 : exp_err);
    chk({tag, "_errpulses"}, err_seen, exp_err);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
    in_TDATA  = 8'h00;
    tick();
    #1 chk("rst_tready_low", {31'd0, in_TREADY}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    exp_sent = 0;
    exp_err  = 0;
    err_seen = 0;
    #1;
  endtask

  initial begin
    logic [31:0] a, b;
    byte_q_t fb;
    byte_q_t bb;
    int r;

    cmd_out_TREADY = 1'b1;
    do_reset();

    // Reset state
    chk("rst_tvalid", {31'd0, cmd_out_TVALID}, 32'd0);
    chk("rst_tdata", {3'b000, cmd_out_TDATA}, 32'd0);
    chk("rst_sent", {16'd0, cmd_sent_count}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_tready_high", {31'd0, in_TREADY}, 32'd1);

    // Normal frame, 1-cycle latency
    send_frame('{8'h19, 8'h00, 8'h00, 8'h00});
    #1;
    chk("norm_tvalid", {31'd0, cmd_out_TVALID}, 32'd1);
    chk("norm_tdata", {3'b000, cmd_out_TDATA}, 32'h19);
    settle("normal");

    // Backpressure: first command stalls, second 4th byte is held off
    rdy_mode = 2;
    tick();
    a = rand_cmd();
    b = rand_cmd();
    send_frame(word_bytes(a));
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold_valid", {31'd0, cmd_out_TVALID}, 32'd1);
      chk("bp_hold_data", {3'b000, cmd_out_TDATA}, {3'b000, a[28:0]});
      tick();
    end
    bb = word_bytes(b);
    for (int i = 0; i < 3; i++) send_byte(bb[i], 1'b0);
    in_TDATA  = bb[3];
    in_TLAST  = 1'b1;
    in_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_4th_held", {31'd0, in_TREADY}, 32'd0);
      tick();
    end
    rdy_mode = 0;
    tick();
    #1 chk("bp_4th_release", {31'd0, in_TREADY}, 32'd1);
    tick();
    in_TVALID = 1'b0;
    in_TLAST  = 1'b0;
    model_frame(bb);
    #1;
    chk("bp_b2b_valid", {31'd0, cmd_out_TVALID}, 32'd1);
    chk("bp_b2b_data", {3'b000, cmd_out_TDATA}, {3'b000, b[28:0]});
    settle("backpressure");

    // Short frame
    send_frame('{8'h11, 8'h22});
    #1;
    chk("short_pulse", {31'd0, err_pulse}, 32'd1);
    chk("short_novalid", {31'd0, cmd_out_TVALID}, 32'd0);
    settle("short");

    // Long frame, then a good frame
    send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    settle("long");
    send_frame(word_bytes(32'h0000_0A5A));
    settle("after_long");

    // Reserved bit set, then null command
    send_frame('{8'h00, 8'h00, 8'h00, 8'h20});
    #1 chk("resv_novalid", {31'd0, cmd_out_TVALID}, 32'd0);
    send_frame('{8'h00, 8'h00, 8'h00, 8'h00});
    #1 chk("null_novalid", {31'd0, cmd_out_TVALID}, 32'd0);
    settle("invalid");

    // Reset after a partial frame
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    chk("rst_mid_valid", {31'd0, cmd_out_TVALID}, 32'd0);
    chk("rst_mid_err", {24'd0, err_count}, 32'd0);
    chk("rst_mid_sent", {16'd0, cmd_sent_count}, 32'd0);
    send_frame(word_bytes(32'h0012_3456));
    settle("rst_partial");

    // Reset with a pending output beat
    rdy_mode = 2;
    tick();
    send_frame(word_bytes(rand_cmd()));
    #1 chk("pend_valid", {31'd0, cmd_out_TVALID}, 32'd1);
    do_reset();
    chk("pend_rst_valid", {31'd0, cmd_out_TVALID}, 32'd0);
    chk("pend_rst_sent", {16'd0, cmd_sent_count}, 32'd0);
    send_frame(word_bytes(32'h1000_0001));
    settle("rst_pending");

    // Randomized frames with random output backpressure
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      fb.delete();
      if (r == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) fb.push_back(8'($urandom));
      end else if (r == 1) begin
        for (int k = 0; k < $urandom_range(5, 7); k++) fb.push_back(8'($urandom));
      end else begin
        fb = word_bytes(rand_word());
      end
      send_frame(fb);
    end
    settle("random");

    // Error counter saturation
    for (int i = 0; i < 260; i++) send_frame('{8'($urandom)});
    settle("saturate");
    send_frame(word_bytes(32'h0000_0042));
    settle("after_saturate");

`ifdef DBG_CMD_TX_TIMEOUT_EN
    do_reset();
    send_byte(8'h55, 1'b0);
    repeat (20) tick();
    exp_err++;
    chk("timeout_err", {24'd0, err_count}, 32'd1);
    send_frame(word_bytes(32'h0000_0123));
    settle("timeout");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_tx.md
Name: dbg_cmd_tx

Overview:
- Transmitter end of the 29-bit debug command stream consumed by the governor control FSM.
- Accepts a host byte stream (UART/network bridge, AXI-Stream, 8-bit) carrying 4-byte little-endian command frames.
- Validates each frame and issues one 29-bit command beat per valid frame on cmd_out, with full AXI-Stream valid/ready handshake.
- Sits between the host link and the control FSM's command input; also keeps sent/error counters for status readback.

Parameters:
- CMD_W, 29, command width; must equal the control FSM command width.
- CNT_W, 16, width of the sent-command counter.
- TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_TDATA  in  8  host byte
- in_TVALID  in  1  host byte valid
- in_TREADY  out  1  host byte accepted
- in_TLAST  in  1  last byte of frame
- cmd_out_TDATA  out  CMD_W  command to the control FSM
- cmd_out_TVALID  out  1  command valid
- cmd_out_TREADY  in  1  control FSM ready
- cmd_sent_count  out  CNT_W  commands handed off; wraps
- err_count  out  8  discarded frames; saturates at 255
- err_pulse  out  1  one-cycle pulse per discarded frame

Behaviour:
- Reset: synchronous, active-high, only on the clk edge with rst=1.
  - All outputs and internal state clear: in_TREADY=0 during rst, cmd_out_TVALID=0, cmd_out_TDATA=0, counters=0, err_pulse=0.
  - FSM goes to COLLECT with byte_idx=0.
  - A partial frame or a pending output beat is dropped without counting.
- Input beat: fires when in_TVALID && in_TREADY.
- in_TREADY is 1 except in these cases:
  - during rst;
  - in COLLECT with byte_idx=3 while the output slot is occupied and not draining this cycle. The 4th byte is held off until cmd_out_TVALID && cmd_out_TREADY, or the slot is empty.
- Assembly: byte k lands in shift bits [8k+7:8k]. This gives 32 raw bits; bits [31:29] are reserved.
- FSM COLLECT:
  - Beat with byte_idx<3 and TLAST=0: byte_idx++.
  - Beat with byte_idx<3 and TLAST=1: short frame. Discard, error, byte_idx=0.
  - Beat with byte_idx=3 and TLAST=1: frame complete; validate.
  - Beat with byte_idx=3 and TLAST=0: long frame. Error, go to DRAIN.
- FSM DRAIN:
  - Accept and discard beats until a beat with TLAST=1.
  - Then go to COLLECT with byte_idx=0.
  - The error is counted once, on entry to DRAIN.
- Validation of a complete frame:
  - Reserved bits nonzero: error.
  - Command bits [28:0]==0: error, because the FSM ignores null commands.
  - Otherwise load the output slot.
- Output slot:
  - Loaded the cycle after the 4th-byte beat.
  - Latency from last-byte handshake to cmd_out_TVALID is 1 cycle.
  - TVALID holds and TDATA stays stable until cmd_out_TREADY.
  - Back-to-back commands are allowed: drain and load in the same cycle gives no bubble.
- cmd_sent_count increments on each cmd_out handshake and wraps modulo 2^CNT_W.
- Errors: err_pulse=1 for exactly one cycle per discarded frame; err_count increments and saturates at 255.
- Simultaneous events: an output handshake and a new load in the same cycle: count the send, slot stays valid with the new data.

Optional Feature:
- Macro: DBG_CMD_TX_TIMEOUT_EN.
- Defined:
  - A counter runs while byte_idx!=0 in COLLECT, or while in DRAIN, and resets on each input beat.
  - On reaching TIMEOUT_CYCLES-1 idle cycles: abandon the frame, go to COLLECT with byte_idx=0, and raise one error.
  - A frame already in DRAIN is not counted a second time.
- Undefined: no counter logic; a partial frame waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package dbg_cmd_pkg holds:
  - CMD_W;
  - command bit-index constants: CMD_CONT_EN=0, CMD_PAUSE_R=1, CMD_PAUSE_W=2, CMD_DROP_R=3, CMD_DROP_W=4, CMD_INJ_R=5, CMD_INJ_W=6, CMD_LOG_*=7..11, CMD_INJ_RESP=12;
  - the tx state enum {COLLECT, DRAIN}.
- The control FSM shares the same package.
- One sub-module, dbg_cmd_slot: a single-entry valid/ready output register with simultaneous load and drain.

Test Plan:
- Normal frame: bytes 0x19,0x00,0x00,0x00 with TLAST on the 4th, TREADY=1. Expect cmd_out_TDATA=0x0000019 with TVALID one cycle after the last byte; cmd_sent_count=1.
- Backpressure: hold cmd_out_TREADY=0 for 10 cycles after a valid frame, then send a second frame. Expect TDATA stable and in_TREADY=0 on the second frame's 4th byte until the drain; both commands delivered in order; count=2.
- Short and long frames:
  - 2 bytes with TLAST on the 2nd: expect err_pulse, err_count=1, nothing issued.
  - 6 bytes with TLAST on the 6th: expect err_count=2, then a following valid frame is issued.
- Invalid content: frame 0x00,0x00,0x00,0x20 (reserved bit 29 set), then an all-zero frame. Expect err_count=2 and no cmd_out_TVALID.
- Reset mid-operation: assert rst after 2 bytes, and again with a pending output beat. Expect TVALID=0 and counters=0; the next valid frame is issued correctly from byte 0.
- Timeout (with DBG_CMD_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16): send 1 byte, then idle 20 cycles. Expect err_count=1, and the next 4-byte frame is accepted as a fresh frame.
